// File: rtl/host_step_link.sv
// host_step_link: host-side single-step/batch controller for a CPU, driven
// over a byte-stream UART. The host queues up to IBUF_DEPTH instructions per
// command. Each step pulses cpu_run once. CPU data-memory accesses seen in a
// step are forwarded to the host. All multi-byte words go MSB byte first.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rx_valid, rx_data   received byte strobe / byte
//   tx_valid, tx_data   byte to send, held until tx_ready
//   tx_ready            UART accepts tx_data this cycle
//   pc                  current CPU program counter
//   cpu_reset, cpu_run  one-cycle CPU reset / clock-enable pulses
//   instr               instruction presented to the CPU
//   mem_*               CPU memory request sampled in the run cycle
//   mem_rdata           load data returned by the host
//   busy, state_dbg     not-idle flag, current state encoding
//
// Build option: define HOST_LINK_TIMEOUT_EN to abort rx waits (other than
// the command wait) after TIMEOUT_CYC idle cycles, answering with 0xEE.
module host_step_link #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IBUF_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic [DATA_W-1:0] instr,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_wmask,
  input  logic [2:0]        mem_rsize,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [3:0]        state_dbg
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned NA    = ADDR_W / 8;
  localparam int unsigned NP    = PC_W / 8;
  localparam int unsigned SH_W0 = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned SH_W  = (SH_W0 > PC_W) ? SH_W0 : PC_W;
  localparam int unsigned BC_W  = $clog2(SH_W / 8) + 1;
  localparam int unsigned IDX_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [3:0] {
    RST_CPU   = 4'd0,
    ACK       = 4'd1,
    ERR       = 4'd2,
    WAIT_CMD  = 4'd3,
    SEND_PC   = 4'd4,
    RX_INSTR  = 4'd5,
    RX_COUNT  = 4'd6,
    EXEC      = 4'd7,
    CPU_CLK   = 4'd8,
    TX_ADDR   = 4'd9,
    TX_CTRL   = 4'd10,
    TX_WDATA  = 4'd11,
    RX_RDATA  = 4'd12,
    STEP_DONE = 4'd13
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ibuf [IBUF_DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  widx;
  logic [CNT_W-1:0]  count;
  logic [BC_W-1:0]   bcnt;
  logic [DATA_W-1:0] rx_sh;
  logic [SH_W-1:0]   tx_sh;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [7:0]        ctrl_q;
  logic [DATA_W-1:0] rx_word;
  logic [BC_W-1:0]   tx_last;
  state_t            tx_next;
  logic              to_hit;

  assign state_dbg = state;
  // Word completed by the byte arriving this cycle.
  assign rx_word = (rx_sh << 8) | DATA_W'(rx_data);

`ifdef HOST_LINK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            rx_wait;

  assign rx_wait = (state == RX_INSTR) || (state == RX_COUNT) || (state == RX_RDATA);
  assign to_hit  = rx_wait && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter for the data rx waits; restarts on every byte.
  always_ff @(posedge clk) begin
    if (reset || !rx_wait || rx_valid) to_cnt <= '0;
    else                               to_cnt <= to_cnt + TO_W'(1);
  end
`else
  // No timeout in this build; rx waits are unbounded.
  assign to_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // Length and successor of the multi-byte send in progress.
  always_comb begin
    tx_last = BC_W'(NP - 1);
    tx_next = ACK;
    case (state)
      TX_ADDR:  begin tx_last = BC_W'(NA - 1); tx_next = TX_CTRL;   end
      TX_WDATA: begin tx_last = BC_W'(NB - 1); tx_next = STEP_DONE; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_CPU;
      busy      <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      cpu_reset <= 1'b0;
      cpu_run   <= 1'b0;
      instr     <= '0;
      mem_rdata <= '0;
      idx       <= '0;
      widx      <= '0;
      count     <= '0;
      bcnt      <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ctrl_q    <= 8'h00;
      for (int unsigned i = 0; i < IBUF_DEPTH; i++) ibuf[i] <= '0;
    end else begin
      cpu_reset <= 1'b0;
      cpu_run   <= 1'b0;
      unique case (state)
        RST_CPU: begin
          cpu_reset <= 1'b1;
          count     <= '0;
          idx       <= '0;
          widx      <= '0;
          for (int unsigned i = 0; i < IBUF_DEPTH; i++) ibuf[i] <= '0;
          state     <= ACK;
        end
        ACK, ERR: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= (state == ACK) ? 8'h01 : 8'hEE;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= WAIT_CMD;
          end
        end
        WAIT_CMD: begin
          if (rx_valid) begin
            busy <= 1'b1;
            idx  <= '0;
            bcnt <= '0;
            case (rx_data)
              8'h01: state <= RST_CPU;
              8'h02: begin
                tx_sh <= SH_W'(pc) << (SH_W - PC_W);
                state <= SEND_PC;
              end
              8'h03: begin
                count <= CNT_W'(1);
                widx  <= '0;
                state <= RX_INSTR;
              end
              8'h04:   state <= RX_COUNT;
              default: state <= ERR;
            endcase
          end
        end
        // Byte-serial senders share one handshake; tx_data held until taken.
        SEND_PC, TX_ADDR, TX_WDATA: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= tx_sh[SH_W-1 -: 8];
            tx_sh    <= tx_sh << 8;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            bcnt     <= bcnt + BC_W'(1);
            if (bcnt == tx_last) begin
              bcnt  <= '0;
              state <= tx_next;
            end
          end
        end
        RX_COUNT: begin
          if (rx_valid) begin
            if (rx_data == 8'h00 || 32'(rx_data) > IBUF_DEPTH) begin
              state <= ERR;
            end else begin
              count <= CNT_W'(rx_data);
              widx  <= '0;
              state <= RX_INSTR;
            end
          end else if (to_hit) begin
            state <= ERR;
          end
        end
        RX_INSTR: begin
          if (rx_valid) begin
            rx_sh <= rx_word;
            bcnt  <= bcnt + BC_W'(1);
            if (bcnt == BC_W'(NB - 1)) begin
              bcnt       <= '0;
              ibuf[widx] <= rx_word;
              if (CNT_W'(widx) + CNT_W'(1) == count) begin
                // Load the first instruction now so it is stable one cycle
                // before cpu_run; a single-word batch is still in flight.
                instr <= (widx == '0) ? rx_word : ibuf[0];
                idx   <= '0;
                state <= EXEC;
              end else begin
                widx <= widx + IDX_W'(1);
              end
            end
          end else if (to_hit) begin
            state <= ERR;
          end
        end
        EXEC: begin
          cpu_run <= 1'b1;
          state   <= CPU_CLK;
        end
        // cpu_run is high in this cycle: capture the CPU's memory request.
        CPU_CLK: begin
          we_q    <= mem_we;
          wdata_q <= mem_wdata;
          ctrl_q  <= mem_we ? {2'b01, 4'b0000, mem_wmask} : {2'b10, 3'b000, mem_rsize};
          tx_sh   <= SH_W'(mem_addr) << (SH_W - ADDR_W);
          bcnt    <= '0;
          state   <= (mem_we || mem_re) ? TX_ADDR : STEP_DONE;
        end
        TX_CTRL: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= ctrl_q;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            bcnt     <= '0;
            if (we_q) begin
              tx_sh <= SH_W'(wdata_q) << (SH_W - DATA_W);
              state <= TX_WDATA;
            end else begin
              state <= RX_RDATA;
            end
          end
        end
        RX_RDATA: begin
          if (rx_valid) begin
            rx_sh <= rx_word;
            bcnt  <= bcnt + BC_W'(1);
            if (bcnt == BC_W'(NB - 1)) begin
              bcnt      <= '0;
              mem_rdata <= rx_word;
              state     <= STEP_DONE;
            end
          end else if (to_hit) begin
            state <= ERR;
          end
        end
        STEP_DONE: begin
          if (CNT_W'(idx) + CNT_W'(1) < count) begin
            idx   <= idx + IDX_W'(1);
            instr <= ibuf[idx + IDX_W'(1)];
            state <= EXEC;
          end else begin
            idx   <= '0;
            state <= ACK;
          end
        end
        default: state <= RST_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_host_step_link.sv
// Directed bench for host_step_link: host commands in, tx bytes and
// cpu_run pulses logged in order and compared with hand-written sequences.
module tb_host_step_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [31:0] pc = 32'h0000_0104;
  logic        cpu_reset;
  logic        cpu_run;
  logic [31:0] instr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr = 32'h0000_2000;
  logic [31:0] mem_wdata = 32'h1234_5678;
  logic [1:0]  mem_wmask = 2'b11;
  logic [2:0]  mem_rsize = 3'b010;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [3:0]  state_dbg;

  logic [31:0] we_instr = 32'hFFFF_FFFF;
  logic [31:0] re_instr = 32'hFFFF_FFFF;

  int checks = 0;
  int failures = 0;
  int runs = 0;
  int rst_pulses = 0;
  int rdy_ph = 0;
  logic [15:0] ev_q[$];
  logic [15:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [7:0]  hold_d = 8'h00;

  // The CPU model: instruction decides whether this step stores or loads.
  assign mem_we = (instr == we_instr);
  assign mem_re = (instr == re_instr);

  host_step_link dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pc(pc), .cpu_reset(cpu_reset), .cpu_run(cpu_run), .instr(instr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rsize(mem_rsize),
    .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // UART accepts two cycles out of three.
  always @(posedge clk) begin
    #1;
    tx_ready = (rdy_ph != 2);
    rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
  end

  // Event log: accepted tx bytes {00,byte} and run pulses {C0,instr[7:0]}.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) ev_q.push_back({8'h00, tx_data});
      if (cpu_run) begin
        ev_q.push_back({8'hC0, instr[7:0]});
        runs++;
      end
      if (cpu_reset) rst_pulses++;
      if (hold_v && tx_valid) chk("tx_hold", 32'(tx_data), 32'(hold_d));
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ev(input int cnt, input string tag);
    int n = 0;
    while (ev_q.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 32'(ev_q.size() >= cnt), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(ev_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_log();
    ev_q.delete();
    runs = 0;
    rst_pulses = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);

    // Release reset: one cpu_reset cycle, then ACK, then idle.
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_idle("boot");
    exp_q = '{16'h0001};
    check_log("boot");
    chk("boot_rst_pulse", 32'(rst_pulses), 32'd1);
    chk("boot_state", 32'(state_dbg), 32'd3);

    // Read PC.
    clear_log();
    send_byte(8'h02);
    wait_idle("pc");
    exp_q = '{16'h0000, 16'h0000, 16'h0001, 16'h0004, 16'h0001};
    check_log("pc");

    // Single step, no memory access; cpu_run two cycles after last byte.
    clear_log();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h93);
    @(negedge clk);
    chk("step_lat1_run", 32'(cpu_run), 32'd0);
    chk("step_instr_pre", instr, 32'h00A0_0093);
    @(negedge clk);
    chk("step_lat2_run", 32'(cpu_run), 32'd1);
    wait_idle("step");
    exp_q = '{16'hC093, 16'h0001};
    check_log("step");
    chk("step_runs", 32'(runs), 32'd1);
    chk("step_instr", instr, 32'h00A0_0093);

    // Load step: address + 0x82 out, host returns DE AD BE EF.
    clear_log();
    re_instr = 32'h0000_A103;
    send_byte(8'h03);
    send_word(32'h0000_A103);
    wait_ev(6, "ld");
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    @(negedge clk);
    chk("ld_rdata_partial", mem_rdata, 32'd0);
    send_byte(8'hEF);
    wait_idle("ld");
    chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
    exp_q = '{16'hC003, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0082, 16'h0001};
    check_log("ld");

    // Batch of three, second one stores 0x12345678 with wmask 2'b11.
    clear_log();
    re_instr = 32'hFFFF_FFFF;
    we_instr = 32'h00B1_2023;
    send_byte(8'h04);
    send_byte(8'h03);
    send_word(32'h0010_0093);
    send_word(32'h00B1_2023);
    send_word(32'h0020_0113);
    wait_idle("batch");
    exp_q = '{16'hC093, 16'hC023, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0043,
              16'h0012, 16'h0034, 16'h0056, 16'h0078, 16'hC013, 16'h0001};
    check_log("batch");
    chk("batch_instr", instr, 32'h0020_0113);

    // Batch count out of range: N=5 then N=0.
    clear_log();
    send_byte(8'h04);
    send_byte(8'h05);
    wait_idle("n5");
    exp_q = '{16'h00EE};
    check_log("n5");
    chk("n5_runs", 32'(runs), 32'd0);

    clear_log();
    send_byte(8'h04);
    send_byte(8'h00);
    wait_idle("n0");
    exp_q = '{16'h00EE};
    check_log("n0");

    // Unknown command.
    clear_log();
    send_byte(8'h7F);
    wait_idle("bad");
    exp_q = '{16'h00EE};
    check_log("bad");

    // Reset command.
    clear_log();
    send_byte(8'h01);
    wait_idle("rcmd");
    exp_q = '{16'h0001};
    check_log("rcmd");
    chk("rcmd_rst_pulse", 32'(rst_pulses), 32'd1);
    chk("rcmd_runs", 32'(runs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
